shiftreg_universal: RTL



---
 rtl/shiftreg_universal.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shiftreg_universal.sv
// shiftreg_universal: universal shift register with run-time mode, multi-bit step and counted burst engine
//
// Optional feature: define SHIFTREG_LFSR_EN to turn mode 3'b110 into a Fibonacci
// LFSR using TAPS; without it mode 3'b110 holds and no LFSR logic exists.
//
// Ports:
//   clock     in   rising-edge clock
//   aclr_n    in   asynchronous active-low reset (q=RESET_VALUE, burst aborted)
//   sclr      in   synchronous clear (q=0), highest synchronous priority
//   sset      in   synchronous set (q=LOAD_SVALUE)
//   enable    in   shift qualifier, also qualifies load
//   load      in   parallel load of data (with enable)
//   data      in   parallel load value
//   mode      in   000 hold, 001 SL, 010 SR, 011 ROL, 100 ROR, 101 ASR, 110 LFSR/hold, 111 hold
//   shiftin   in   serial input bits (STEP wide)
//   start     in   burst start request, honoured only in IDLE
//   count     in   number of shifts in a burst
//   busy      out  burst in progress
//   done      out  one-cycle burst-complete pulse
//   shiftout  out  registered bits shifted out
//   q         out  register contents
module shiftreg_universal #(
   parameter int                 WIDTH       = 8,
   parameter int                 STEP        = 1,
   parameter int                 CNT_WIDTH   = 4,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter logic [WIDTH-1:0]   LOAD_SVALUE = WIDTH'(3),
   parameter logic [WIDTH-1:0]   TAPS        = WIDTH'(8'hB8)
) (
   input  logic                 clock,
   input  logic                 aclr_n,
   input  logic                 sclr,
   input  logic                 sset,
   input  logic                 enable,
   input  logic                 load,
   input  logic [WIDTH-1:0]     data,
   input  logic [2:0]           mode,
   input  logic [STEP-1:0]      shiftin,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] count,
   output logic                 busy,
   output logic                 done,
   output logic [STEP-1:0]      shiftout,
   output logic [WIDTH-1:0]     q
);
   typedef enum logic {IDLE, BURST} state_e;
   state_e               state_q, state_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [STEP-1:0]      so_q, so_d;
   logic [2:0]           mode_q, mode_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 sync_op, burst_shift, free_shift, do_shift, sh_hold;
   logic [2:0]           act_mode;
   logic [WIDTH-1:0]     sh_val;
   logic [STEP-1:0]      sh_out;
   // any clear/set/load pre-empts shifting and terminates a running burst
   assign sync_op     = sclr | sset | (enable & load);
   assign burst_shift = (state_q == BURST) & enable & ~sync_op;
   assign free_shift  = (state_q == IDLE) & enable & ~sync_op & ~start;
   assign do_shift    = burst_shift | free_shift;
   assign act_mode    = (state_q == BURST) ? mode_q : mode;
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q <= IDLE;
         q_q     <= RESET_VALUE;
         so_q    <= '0;
         mode_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         so_q    <= so_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (sync_op) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == IDLE && start) begin
         state_d = (count == '0) ? IDLE : BURST;
         done_d  = (count == '0);
         cnt_d   = count;
         mode_d  = mode;
      end else if (burst_shift) begin
         // the counter runs even in latched hold mode
         cnt_d   = cnt_q - CNT_WIDTH'(1);
         state_d = (cnt_q == CNT_WIDTH'(1)) ? IDLE : BURST;
         done_d  = (cnt_q == CNT_WIDTH'(1));
      end
   end
   always_comb begin
      sh_hold = 1'b0;
      sh_out  = q_q[WIDTH-1-:STEP];
      sh_val  = q_q;
      case (act_mode)
         3'b001: sh_val = {q_q[WIDTH-STEP-1:0], shiftin};
         3'b010: begin
            sh_val = {shiftin, q_q[WIDTH-1:STEP]};
            sh_out = q_q[STEP-1:0];
         end
         3'b011: sh_val = {q_q[WIDTH-STEP-1:0], q_q[WIDTH-1-:STEP]};
         3'b100: begin
            sh_val = {q_q[STEP-1:0], q_q[WIDTH-1:STEP]};
            sh_out = q_q[STEP-1:0];
         end
         3'b101: begin
            sh_val = {{STEP{q_q[WIDTH-1]}}, q_q[WIDTH-1:STEP]};
            sh_out = q_q[STEP-1:0];
         end
`ifdef SHIFTREG_LFSR_EN
         // LFSR always advances one bit, independent of STEP
         3'b110: begin
            sh_val = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
            sh_out = STEP'(q_q[WIDTH-1]);
         end
`endif
         default: sh_hold = 1'b1;
      endcase
   end
   assign q_d  = sclr               ? '0          :
                 sset               ? LOAD_SVALUE :
                 (enable & load)    ? data        :
                 (do_shift & ~sh_hold) ? sh_val   : q_q;
   assign so_d = (do_shift & ~sh_hold & ~sync_op) ? sh_out : so_q;
   assign q        = q_q;
   assign shiftout = so_q;
   assign busy     = (state_q == BURST);
   assign done     = done_q;
endmodule
